// File: rtl/soml_tx_encoder.sv
// SOML transmit encoder: maps a 12-bit word to two 16-QAM symbols and a rotated
// Alamouti dispersion block, then streams the 4x2 block as 8 complex samples.
`timescale 1ns/1ps
module soml_tx_encoder #(
  parameter int N = 32,
  parameter int Q = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [11:0]         data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] x_r,
  output logic signed [N-1:0] x_i,
  output logic [1:0]          ant_idx,
  output logic                slot_idx,
  output logic                out_last,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; a valid source holds its payload stable until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, MAP = 2'd1, SEND = 2'd2} state_t;

  localparam logic signed [N-1:0] ONE   = N'(1) << Q;
  localparam logic signed [N-1:0] THREE = ONE + ONE + ONE;

  state_t                state, state_nxt;
  logic [2:0]            beat;
  logic [11:0]           data_q;
  logic signed [N-1:0]   buf_r [8];
  logic signed [N-1:0]   buf_i [8];
  logic signed [N-1:0]   map_r [8];
  logic signed [N-1:0]   map_i [8];
  logic signed [N-1:0]   s1r, s1i, s2r, s2i;
  logic signed [N-1:0]   b0r, b0i, b1r, b1i;
  logic [1:0]            ant_a, ant_b;

  function automatic logic signed [N-1:0] pam(input logic [1:0] g);
    case (g)
      2'b00:   return -THREE;
      2'b01:   return -ONE;
      2'b11:   return ONE;
      default: return THREE;
    endcase
  endfunction

  // Symbol mapping and dispersion; j^r is a swap/negate of the b-antenna samples.
  always_comb begin
    s1r = pam(data_q[7:6]);
    s1i = pam(data_q[5:4]);
    s2r = pam(data_q[3:2]);
    s2i = pam(data_q[1:0]);
    case (data_q[11:10])
      2'b00:   begin ant_a = 2'd0; ant_b = 2'd1; end
      2'b01:   begin ant_a = 2'd2; ant_b = 2'd3; end
      2'b10:   begin ant_a = 2'd0; ant_b = 2'd2; end
      default: begin ant_a = 2'd1; ant_b = 2'd3; end
    endcase
    case (data_q[9:8])
      2'd0:    begin b0r =  s2r; b0i =  s2i; b1r =  s1r; b1i = -s1i; end
      2'd1:    begin b0r = -s2i; b0i =  s2r; b1r =  s1i; b1i =  s1r; end
      2'd2:    begin b0r = -s2r; b0i = -s2i; b1r = -s1r; b1i =  s1i; end
      default: begin b0r =  s2i; b0i = -s2r; b1r = -s1i; b1i = -s1r; end
    endcase
    for (int k = 0; k < 8; k++) begin
      map_r[k] = '0;
      map_i[k] = '0;
    end
    map_r[{1'b0, ant_a}] = s1r;
    map_i[{1'b0, ant_a}] = s1i;
    map_r[{1'b1, ant_a}] = -s2r;
    map_i[{1'b1, ant_a}] = s2i;
    map_r[{1'b0, ant_b}] = b0r;
    map_i[{1'b0, ant_b}] = b0i;
    map_r[{1'b1, ant_b}] = b1r;
    map_i[{1'b1, ant_b}] = b1i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == MAP)
        beat <= 3'd0;
      else if (state == SEND && out_ready)
        beat <= beat + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid)
      data_q <= data_in;
    if (state == MAP) begin
      for (int k = 0; k < 8; k++) begin
        buf_r[k] <= map_r[k];
        buf_i[k] <= map_i[k];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    x_r       = '0;
    x_i       = '0;
    ant_idx   = 2'd0;
    slot_idx  = 1'b0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    state_dbg = state;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nxt = MAP;
      end
      MAP: state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        x_r       = buf_r[beat];
        x_i       = buf_i[beat];
        ant_idx   = beat[1:0];
        slot_idx  = beat[2];
        out_last  = (beat == 3'd7);
        if (out_ready && beat == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_soml_tx_encoder.sv
// Bench for soml_tx_encoder: a complex-arithmetic block model feeds an expected
// queue; the stream is checked beat by beat under random backpressure.
`timescale 1ns/1ps
module tb_soml_tx_encoder;
  localparam int N = 32;
  localparam int Q = 22;
  localparam int W = 68;

  logic                clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [11:0]         data_in;
  logic signed [N-1:0] x_r, x_i;
  logic [1:0]          ant_idx, state_dbg;
  logic                slot_idx, out_last, busy;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  soml_tx_encoder #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_r(x_r), .x_i(x_i), .ant_idx(ant_idx), .slot_idx(slot_idx),
    .out_last(out_last), .busy(busy), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Block model in plain complex arithmetic: X[ant][slot] in integer units.
  function automatic void push_model(input logic [11:0] w);
    int lv[4];
    int pa[4];
    int pb[4];
    int xr[4][2];
    int xi[4][2];
    int s1r, s1i, s2r, s2i, pr, pm, t, a, b, r;
    logic [N-1:0] er, ei;
    lv = '{-3, -1, 3, 1};
    pa = '{0, 2, 0, 1};
    pb = '{1, 3, 2, 3};
    s1r = lv[w[7:6]]; s1i = lv[w[5:4]];
    s2r = lv[w[3:2]]; s2i = lv[w[1:0]];
    a = pa[w[11:10]]; b = pb[w[11:10]]; r = int'(w[9:8]);
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 2; s++) begin
        xr[i][s] = 0;
        xi[i][s] = 0;
      end
    xr[a][0] = s1r;  xi[a][0] = s1i;
    xr[a][1] = -s2r; xi[a][1] = s2i;
    pr = s2r; pm = s2i;
    for (int k = 0; k < r; k++) begin t = pr; pr = -pm; pm = t; end
    xr[b][0] = pr; xi[b][0] = pm;
    pr = s1r; pm = -s1i;
    for (int k = 0; k < r; k++) begin t = pr; pr = -pm; pm = t; end
    xr[b][1] = pr; xi[b][1] = pm;
    for (int k = 0; k < 8; k++) begin
      er = N'(xr[k % 4][k / 4] * (1 << Q));
      ei = N'(xi[k % 4][k / 4] * (1 << Q));
      exp_q.push_back({(k == 7), 1'(k / 4), 2'(k % 4), er, ei});
    end
  endfunction

  task automatic start_word(input logic [11:0] w, input bit hold);
    check("in_ready_idle", W'(in_ready), W'(1));
    data_in  = w;
    in_valid = 1'b1;
    push_model(w);
    @(negedge clk);
    check("map_cycle", W'({busy, out_valid, in_ready}), W'(3'b100));
    if (!hold) in_valid = 1'b0;
    @(negedge clk);
    check("latency", W'(out_valid), W'(1));
  endtask

  task automatic drain(input int limit, input int stall_pct);
    int hs = 0;
    int cyc = 0;
    logic rdy;
    while (hs < limit && cyc < 200) begin
      check("in_ready_busy", W'(in_ready), W'(0));
      check("valid_held", W'(out_valid), W'(1));
      if (exp_q.size() > 0)
        check("beat", {out_last, slot_idx, ant_idx, x_r, x_i}, exp_q[0]);
      else
        check("beat_unexpected", W'(out_valid), W'(0));
      rdy = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      if (out_valid && rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("handshakes", W'(hs), W'(limit));
    if (limit == 8)
      check("idle_after_block", W'({busy, out_valid, in_ready}), W'(3'b001));
  endtask

  initial begin
    logic [11:0] w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_fields", W'({out_last, slot_idx, ant_idx, state_dbg}), W'(0));
    check("rst_x", W'({x_r, x_i}), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed words from the test plan.
    start_word(12'h000, 1'b0); drain(8, 0);
    start_word({4'b0101, 8'b10_01_11_00}, 1'b0); drain(8, 0);

    // Every matrix index with b1 = 0.
    for (int q = 0; q < 16; q++) begin
      w = {4'(q), 8'h00};
      start_word(w, 1'b0); drain(8, 0);
    end

    // Same word under heavy random backpressure, then random words.
    start_word(12'h59C, 1'b0); drain(8, 50);
    for (int i = 0; i < 6; i++) begin
      w = 12'($urandom_range(4095));
      start_word(w, 1'b0); drain(8, 40);
    end

    // in_valid held high across two words.
    start_word(12'hA37, 1'b1); drain(8, 20);
    start_word(12'h3C5, 1'b0); drain(8, 30);

    // Reset in the middle of a block (at beat 4), then a fresh block.
    start_word(12'hE6B, 1'b0); drain(4, 0);
    check("pre_rst_beat4", W'({slot_idx, ant_idx}), W'(3'b100));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_state", W'({out_valid, busy, in_ready, state_dbg}), W'(0));
    check("midrst_x", W'({x_r, x_i, out_last}), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    start_word(12'h7D2, 1'b0); drain(8, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
